// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Two-master (CPU, DMA) arbiter in front of an SDRAM core, with periodic
//   auto-refresh scheduling and access timeout.
//
// Ports
//   CLK, RST                 clock; asynchronous active-high reset
//   SD_READY                 core finished power-up init
//   CPU_REQ/RW/A/UDS/LDS     CPU level request and access fields (strobes active-low)
//   DMA_REQ/RW/A/UDS/LDS     DMA level request and access fields
//   CPU_ACK, DMA_ACK         one-cycle completion pulses
//   CPU_GNT, DMA_GNT         high while that master owns the SDRAM port
//   SD_AS                    active-low access strobe to the core
//   SD_A/SD_RW/SD_UDS/SD_LDS access fields latched at grant
//   SD_VALID                 active-low access-complete from the core
//   SD_REFRESH, SD_REFDONE   refresh request / one-cycle refresh-complete pulse
//   REFRESH_LATE             sticky: refresh interval expired with a refresh pending
//   ERR                      one-cycle pulse on access timeout
module sdram_arbiter #(
  parameter int unsigned REFRESH_INTERVAL = 128,
  parameter int unsigned TIMEOUT          = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SD_READY,
  input  logic        CPU_REQ,
  input  logic        DMA_REQ,
  input  logic        CPU_RW,
  input  logic        DMA_RW,
  input  logic [23:1] CPU_A,
  input  logic [23:1] DMA_A,
  input  logic        CPU_UDS,
  input  logic        CPU_LDS,
  input  logic        DMA_UDS,
  input  logic        DMA_LDS,
  output logic        CPU_ACK,
  output logic        DMA_ACK,
  output logic        CPU_GNT,
  output logic        DMA_GNT,
  output logic        SD_AS,
  output logic [23:1] SD_A,
  output logic        SD_RW,
  output logic        SD_UDS,
  output logic        SD_LDS,
  input  logic        SD_VALID,
  output logic        SD_REFRESH,
  input  logic        SD_REFDONE,
  output logic        REFRESH_LATE,
  output logic        ERR
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CPU,
    S_DMA,
    S_REFRESH,
    S_RELEASE
  } state_t;

  localparam logic [11:0] REF_LAST  = 12'(REFRESH_INTERVAL - 1);
  localparam logic [9:0]  WAIT_LAST = 10'(TIMEOUT - 1);

  state_t      state_q;
  logic [11:0] ref_cnt_q, ref_cnt_d;
  logic [9:0]  wait_q;
  logic [4:0]  dma_loss_q;
  logic        pending_q;
  logic        after_ref_q;
  logic        late_q;
  logic        sd_as_q;
  logic        sd_refresh_q;
  logic        cpu_gnt_q, dma_gnt_q;
  logic        cpu_ack_q, dma_ack_q;
  logic        err_q;
  logic [23:1] sd_a_q;
  logic        sd_rw_q, sd_uds_q, sd_lds_q;

  logic ref_hold;
  logic ref_wrap;
  logic dma_wins;
  logic timed_out;

  // The refresh counter pauses while a refresh is being serviced (REFRESH and
  // the RELEASE cycle that follows it), so on an idle bus the refresh period
  // is REFRESH_INTERVAL + refresh duration + 1. During accesses it keeps
  // running, which is what lets REFRESH_LATE detect an access that outlives
  // two intervals.
  always_comb begin
    ref_hold  = (state_q == S_INIT) || (state_q == S_REFRESH) ||
                ((state_q == S_RELEASE) && after_ref_q);
    ref_wrap  = !ref_hold && (ref_cnt_q == REF_LAST);
    ref_cnt_d = ref_cnt_q;
    if (state_q == S_INIT) begin
      ref_cnt_d = '0;
    end else if (ref_wrap) begin
      ref_cnt_d = '0;
    end else if (!ref_hold) begin
      ref_cnt_d = ref_cnt_q + 12'd1;
    end
    // DMA wins when CPU is absent, or after 16 consecutive losses to CPU.
    dma_wins  = DMA_REQ && (!CPU_REQ || (dma_loss_q == 5'd16));
    timed_out = (wait_q == WAIT_LAST);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_INIT;
      ref_cnt_q    <= '0;
      wait_q       <= '0;
      dma_loss_q   <= '0;
      pending_q    <= 1'b0;
      after_ref_q  <= 1'b0;
      late_q       <= 1'b0;
      sd_as_q      <= 1'b1;
      sd_refresh_q <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dma_gnt_q    <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      err_q        <= 1'b0;
      sd_a_q       <= '0;
      sd_rw_q      <= 1'b1;
      sd_uds_q     <= 1'b1;
      sd_lds_q     <= 1'b1;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      err_q     <= 1'b0;

      // Only one refresh is ever outstanding; a wrap that finds one still
      // pending is recorded as late instead of queued.
      if (ref_wrap) begin
        pending_q <= 1'b1;
        if (pending_q) begin
          late_q <= 1'b1;
        end
      end

      case (state_q)
        S_INIT: begin
          if (SD_READY) begin
            state_q <= S_IDLE;
          end
        end

        S_IDLE: begin
          if (!SD_READY) begin
            state_q <= S_INIT;
          end else if (pending_q) begin
            state_q      <= S_REFRESH;
            sd_refresh_q <= 1'b1;
            pending_q    <= ref_wrap;
          end else if (dma_wins) begin
            state_q    <= S_DMA;
            dma_gnt_q  <= 1'b1;
            sd_as_q    <= 1'b0;
            sd_a_q     <= DMA_A;
            sd_rw_q    <= DMA_RW;
            sd_uds_q   <= DMA_UDS;
            sd_lds_q   <= DMA_LDS;
            wait_q     <= '0;
            dma_loss_q <= '0;
          end else if (CPU_REQ) begin
            state_q    <= S_CPU;
            cpu_gnt_q  <= 1'b1;
            sd_as_q    <= 1'b0;
            sd_a_q     <= CPU_A;
            sd_rw_q    <= CPU_RW;
            sd_uds_q   <= CPU_UDS;
            sd_lds_q   <= CPU_LDS;
            wait_q     <= '0;
            dma_loss_q <= DMA_REQ ? dma_loss_q + 5'd1 : '0;
          end else begin
            dma_loss_q <= '0;
          end
        end

        S_CPU, S_DMA: begin
          if (!SD_VALID || timed_out) begin
            cpu_ack_q   <= (state_q == S_CPU);
            dma_ack_q   <= (state_q == S_DMA);
            err_q       <= SD_VALID;
            cpu_gnt_q   <= 1'b0;
            dma_gnt_q   <= 1'b0;
            sd_as_q     <= 1'b1;
            after_ref_q <= 1'b0;
            state_q     <= S_RELEASE;
          end else begin
            wait_q <= wait_q + 10'd1;
          end
        end

        S_REFRESH: begin
          if (SD_REFDONE) begin
            sd_refresh_q <= 1'b0;
            after_ref_q  <= 1'b1;
            state_q      <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          state_q <= SD_READY ? S_IDLE : S_INIT;
        end

        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign CPU_ACK      = cpu_ack_q;
  assign DMA_ACK      = dma_ack_q;
  assign CPU_GNT      = cpu_gnt_q;
  assign DMA_GNT      = dma_gnt_q;
  assign SD_AS        = sd_as_q;
  assign SD_A         = sd_a_q;
  assign SD_RW        = sd_rw_q;
  assign SD_UDS       = sd_uds_q;
  assign SD_LDS       = sd_lds_q;
  assign SD_REFRESH   = sd_refresh_q;
  assign REFRESH_LATE = late_q;
  assign ERR          = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Directed bench for sdram_arbiter. Two instances share all inputs except
//   reset: u_b (REFRESH_INTERVAL=4095, TIMEOUT=16) covers reset, single access,
//   arbitration fairness, timeout and reset mid-access; u_a
//   (REFRESH_INTERVAL=16, TIMEOUT=255) covers refresh scheduling. The unused
//   instance is held in reset.
module tb_sdram_arbiter;

  logic        clk;
  logic        rst_a, rst_b;
  logic        sd_ready;
  logic        cpu_req, dma_req, cpu_rw, dma_rw;
  logic [23:1] cpu_a, dma_a;
  logic        cpu_uds, cpu_lds, dma_uds, dma_lds;
  logic        sd_valid, sd_refdone;

  logic        a_cpu_ack, a_dma_ack, a_cpu_gnt, a_dma_gnt, a_sd_as;
  logic [23:1] a_sd_a;
  logic        a_sd_rw, a_sd_uds, a_sd_lds, a_sd_refresh, a_late, a_err;

  logic        b_cpu_ack, b_dma_ack, b_cpu_gnt, b_dma_gnt, b_sd_as;
  logic [23:1] b_sd_a;
  logic        b_sd_rw, b_sd_uds, b_sd_lds, b_sd_refresh, b_late, b_err;

  logic [10:0] b_vec;
  assign b_vec = {b_sd_as, b_sd_refresh, b_cpu_gnt, b_dma_gnt, b_cpu_ack,
                  b_dma_ack, b_err, b_late, b_sd_rw, b_sd_uds, b_sd_lds};

  localparam logic [10:0] RESET_VEC = 11'b100_0000_0111;

  int checks = 0;
  int errors = 0;

  sdram_arbiter #(.REFRESH_INTERVAL(16), .TIMEOUT(255)) u_a (
    .CLK(clk), .RST(rst_a), .SD_READY(sd_ready),
    .CPU_REQ(cpu_req), .DMA_REQ(dma_req), .CPU_RW(cpu_rw), .DMA_RW(dma_rw),
    .CPU_A(cpu_a), .DMA_A(dma_a),
    .CPU_UDS(cpu_uds), .CPU_LDS(cpu_lds), .DMA_UDS(dma_uds), .DMA_LDS(dma_lds),
    .CPU_ACK(a_cpu_ack), .DMA_ACK(a_dma_ack), .CPU_GNT(a_cpu_gnt), .DMA_GNT(a_dma_gnt),
    .SD_AS(a_sd_as), .SD_A(a_sd_a), .SD_RW(a_sd_rw), .SD_UDS(a_sd_uds), .SD_LDS(a_sd_lds),
    .SD_VALID(sd_valid), .SD_REFRESH(a_sd_refresh), .SD_REFDONE(sd_refdone),
    .REFRESH_LATE(a_late), .ERR(a_err)
  );

  sdram_arbiter #(.REFRESH_INTERVAL(4095), .TIMEOUT(16)) u_b (
    .CLK(clk), .RST(rst_b), .SD_READY(sd_ready),
    .CPU_REQ(cpu_req), .DMA_REQ(dma_req), .CPU_RW(cpu_rw), .DMA_RW(dma_rw),
    .CPU_A(cpu_a), .DMA_A(dma_a),
    .CPU_UDS(cpu_uds), .CPU_LDS(cpu_lds), .DMA_UDS(dma_uds), .DMA_LDS(dma_lds),
    .CPU_ACK(b_cpu_ack), .DMA_ACK(b_dma_ack), .CPU_GNT(b_cpu_gnt), .DMA_GNT(b_dma_gnt),
    .SD_AS(b_sd_as), .SD_A(b_sd_a), .SD_RW(b_sd_rw), .SD_UDS(b_sd_uds), .SD_LDS(b_sd_lds),
    .SD_VALID(sd_valid), .SD_REFRESH(b_sd_refresh), .SD_REFDONE(sd_refdone),
    .REFRESH_LATE(b_late), .ERR(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if (b_vec !== RESET_VEC) begin
      errors++; $display("FAIL reset_outputs got %b exp %b", b_vec, RESET_VEC);
    end
    checks++;
    if (b_sd_a !== 23'h0) begin
      errors++; $display("FAIL reset_sd_a got %h exp %h", b_sd_a, 23'h0);
    end
    // INIT: no grant, strobe or refresh while SD_READY is low
    rst_b = 1'b0; cpu_req = 1'b1; cpu_a = 23'h000100;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({b_cpu_gnt, b_sd_as, b_sd_refresh, b_cpu_ack} !== 4'b0100) begin
        errors++; $display("FAIL init_hold got %b exp %b",
                           {b_cpu_gnt, b_sd_as, b_sd_refresh, b_cpu_ack}, 4'b0100);
      end
    end
    cpu_req = 1'b0; sd_ready = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_rw = 1'b1; cpu_a = 23'h200000; cpu_uds = 1'b0; cpu_lds = 1'b0; cpu_req = 1'b1;
    tick();
    checks++;
    if ({b_cpu_gnt, b_dma_gnt, b_sd_as} !== 3'b100) begin
      errors++; $display("FAIL read_grant got %b exp %b", {b_cpu_gnt, b_dma_gnt, b_sd_as}, 3'b100);
    end
    checks++;
    if ({b_sd_a, b_sd_rw, b_sd_uds, b_sd_lds} !== {23'h200000, 3'b100}) begin
      errors++; $display("FAIL read_fields got %h/%b exp %h/%b",
                         b_sd_a, {b_sd_rw, b_sd_uds, b_sd_lds}, 23'h200000, 3'b100);
    end
    // request withdrawn and inputs changed: access must carry on unchanged
    cpu_req = 1'b0; cpu_a = 23'h155555; cpu_uds = 1'b1; cpu_lds = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if ({b_sd_a, b_cpu_gnt, b_sd_as, b_cpu_ack} !== {23'h200000, 3'b100}) begin
        errors++; $display("FAIL read_hold cyc %0d got %h/%b exp %h/%b", k, b_sd_a,
                           {b_cpu_gnt, b_sd_as, b_cpu_ack}, 23'h200000, 3'b100);
      end
    end
    sd_valid = 1'b0;
    tick();
    checks++;
    if ({b_cpu_ack, b_cpu_gnt, b_sd_as, b_err} !== 4'b1010) begin
      errors++; $display("FAIL read_ack got %b exp %b", {b_cpu_ack, b_cpu_gnt, b_sd_as, b_err}, 4'b1010);
    end
    sd_valid = 1'b1;
    tick();
    checks++;
    if ({b_cpu_ack, b_cpu_gnt, b_sd_as} !== 3'b001) begin
      errors++; $display("FAIL read_release got %b exp %b", {b_cpu_ack, b_cpu_gnt, b_sd_as}, 3'b001);
    end
    tick();
    checks++;
    if ({b_cpu_ack, b_cpu_gnt, b_sd_as} !== 3'b001) begin
      errors++; $display("FAIL read_idle got %b exp %b", {b_cpu_ack, b_cpu_gnt, b_sd_as}, 3'b001);
    end
  endtask

  task automatic test_arbitration();
    int   n = 0;
    logic ack_due = 1'b0;
    logic due_dma = 1'b0;
    logic exp_dma;
    cpu_a = 23'h000040; cpu_rw = 1'b1; cpu_uds = 1'b0; cpu_lds = 1'b0;
    dma_a = 23'h0ABCDE; dma_rw = 1'b0; dma_uds = 1'b0; dma_lds = 1'b1;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int c = 0; c < 300 && n < 34; c++) begin
      tick();
      if (ack_due) begin
        checks++;
        if ({b_cpu_ack, b_dma_ack} !== (due_dma ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL arb_ack access %0d got %b exp %b", n,
                             {b_cpu_ack, b_dma_ack}, due_dma ? 2'b01 : 2'b10);
        end
        ack_due = 1'b0;
      end
      checks++;
      if ((b_cpu_gnt & b_dma_gnt) !== 1'b0) begin
        errors++; $display("FAIL arb_both_gnt got %b exp %b", b_cpu_gnt & b_dma_gnt, 1'b0);
      end
      if (b_cpu_gnt || b_dma_gnt) begin
        n++;
        exp_dma = ((n % 17) == 0);
        checks++;
        if (b_dma_gnt !== exp_dma) begin
          errors++; $display("FAIL arb_winner access %0d dma_gnt got %b exp %b", n, b_dma_gnt, exp_dma);
        end
        if (exp_dma) begin
          checks++;
          if ({b_sd_a, b_sd_rw, b_sd_uds, b_sd_lds} !== {23'h0ABCDE, 3'b001}) begin
            errors++; $display("FAIL arb_dma_fields got %h/%b exp %h/%b", b_sd_a,
                               {b_sd_rw, b_sd_uds, b_sd_lds}, 23'h0ABCDE, 3'b001);
          end
        end
        ack_due = 1'b1; due_dma = exp_dma;
        sd_valid = 1'b0;
      end else begin
        sd_valid = 1'b1;
      end
    end
    checks++;
    if (n != 34) begin
      errors++; $display("FAIL arb_count got %0d exp %0d", n, 34);
    end
    tick();
    checks++;
    if ({b_cpu_ack, b_dma_ack} !== 2'b01) begin
      errors++; $display("FAIL arb_last_ack got %b exp %b", {b_cpu_ack, b_dma_ack}, 2'b01);
    end
    sd_valid = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    cpu_rw = 1'b0; cpu_a = 23'h7FFFFF; cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    for (int c = 0; c < 16; c++) begin
      checks++;
      if ({b_cpu_gnt, b_cpu_ack, b_err, b_sd_as} !== 4'b1000) begin
        errors++; $display("FAIL timeout_wait cyc %0d got %b exp %b", c,
                           {b_cpu_gnt, b_cpu_ack, b_err, b_sd_as}, 4'b1000);
      end
      tick();
    end
    checks++;
    if ({b_cpu_gnt, b_cpu_ack, b_err, b_sd_as} !== 4'b0111) begin
      errors++; $display("FAIL timeout_abort got %b exp %b",
                         {b_cpu_gnt, b_cpu_ack, b_err, b_sd_as}, 4'b0111);
    end
    tick();
    checks++;
    if ({b_cpu_gnt, b_cpu_ack, b_err, b_sd_as} !== 4'b0001) begin
      errors++; $display("FAIL timeout_release got %b exp %b",
                         {b_cpu_gnt, b_cpu_ack, b_err, b_sd_as}, 4'b0001);
    end
    tick();
  endtask

  task automatic test_rst_mid_dma();
    dma_a = 23'h0ABCDE; dma_rw = 1'b1; dma_uds = 1'b0; dma_lds = 1'b0; dma_req = 1'b1;
    tick();
    checks++;
    if ({b_dma_gnt, b_sd_as} !== 2'b10) begin
      errors++; $display("FAIL rst_pre_grant got %b exp %b", {b_dma_gnt, b_sd_as}, 2'b10);
    end
    tick();
    sd_valid = 1'b0;
    #2 rst_b = 1'b1;
    #1;
    checks++;
    if (b_vec !== RESET_VEC) begin
      errors++; $display("FAIL rst_async got %b exp %b", b_vec, RESET_VEC);
    end
    checks++;
    if (b_sd_a !== 23'h0) begin
      errors++; $display("FAIL rst_async_sd_a got %h exp %h", b_sd_a, 23'h0);
    end
    tick();
    checks++;
    if (b_vec !== RESET_VEC) begin
      errors++; $display("FAIL rst_held got %b exp %b", b_vec, RESET_VEC);
    end
    sd_ready = 1'b0; sd_valid = 1'b1; rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({b_dma_gnt, b_dma_ack, b_sd_as} !== 3'b001) begin
        errors++; $display("FAIL rst_init_hold got %b exp %b", {b_dma_gnt, b_dma_ack, b_sd_as}, 3'b001);
      end
    end
    sd_ready = 1'b1;
    tick();
    checks++;
    if (b_dma_gnt !== 1'b0) begin
      errors++; $display("FAIL rst_idle_gnt got %b exp %b", b_dma_gnt, 1'b0);
    end
    tick();
    checks++;
    if ({b_dma_gnt, b_sd_a} !== {1'b1, 23'h0ABCDE}) begin
      errors++; $display("FAIL rst_regrant got %b/%h exp %b/%h", b_dma_gnt, b_sd_a, 1'b1, 23'h0ABCDE);
    end
    dma_req = 1'b0; sd_valid = 1'b0;
    tick();
    checks++;
    if ({b_dma_ack, b_err} !== 2'b10) begin
      errors++; $display("FAIL rst_regrant_ack got %b exp %b", {b_dma_ack, b_err}, 2'b10);
    end
    sd_valid = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_refresh_idle();
    int   rise[4];
    int   nr = 0;
    int   hi = 0;
    logic prev = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick();
      checks++;
      if ((a_sd_refresh & ~a_sd_as) !== 1'b0) begin
        errors++; $display("FAIL ref_vs_as got %b exp %b", a_sd_refresh & ~a_sd_as, 1'b0);
      end
      if (a_sd_refresh) begin
        if (!prev && nr < 4) begin
          rise[nr] = cyc;
          nr++;
        end
        hi++;
        sd_refdone = (hi == 3);
      end else begin
        sd_refdone = 1'b0;
        hi = 0;
        if (prev && nr == 4) break;
      end
      prev = a_sd_refresh;
    end
    checks++;
    if (nr != 4) begin
      errors++; $display("FAIL ref_count got %0d exp %0d", nr, 4);
    end
    for (int i = 1; i < nr; i++) begin
      checks++;
      if (rise[i] - rise[i-1] != 20) begin
        errors++; $display("FAIL ref_period %0d got %0d exp %0d", i, rise[i] - rise[i-1], 20);
      end
    end
    checks++;
    if (a_late !== 1'b0) begin
      errors++; $display("FAIL ref_late_idle got %b exp %b", a_late, 1'b0);
    end
  endtask

  task automatic test_refresh_late();
    int bad = 0;
    cpu_a = 23'h012345; cpu_rw = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0; cpu_req = 1'b1;
    tick();
    tick();
    checks++;
    if ({a_cpu_gnt, a_sd_as} !== 2'b10) begin
      errors++; $display("FAIL late_grant got %b exp %b", {a_cpu_gnt, a_sd_as}, 2'b10);
    end
    cpu_req = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (a_sd_refresh || !a_cpu_gnt || a_cpu_ack) bad++;
      if (c == 10) begin
        checks++;
        if (a_late !== 1'b0) begin
          errors++; $display("FAIL late_early got %b exp %b", a_late, 1'b0);
        end
      end
      if (c == 40) begin
        checks++;
        if (a_late !== 1'b1) begin
          errors++; $display("FAIL late_set got %b exp %b", a_late, 1'b1);
        end
        sd_valid = 1'b0;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL late_no_preempt got %0d bad cycles exp %0d", bad, 0);
    end
    tick();
    checks++;
    if ({a_cpu_ack, a_err, a_sd_as} !== 3'b101) begin
      errors++; $display("FAIL late_ack got %b exp %b", {a_cpu_ack, a_err, a_sd_as}, 3'b101);
    end
    sd_valid = 1'b1;
    tick();
    checks++;
    if (a_sd_refresh !== 1'b0) begin
      errors++; $display("FAIL late_release_ref got %b exp %b", a_sd_refresh, 1'b0);
    end
    tick();
    checks++;
    if ({a_sd_refresh, a_sd_as} !== 2'b11) begin
      errors++; $display("FAIL late_refresh_start got %b exp %b", {a_sd_refresh, a_sd_as}, 2'b11);
    end
    sd_refdone = 1'b1;
    tick();
    sd_refdone = 1'b0;
    checks++;
    if ({a_sd_refresh, a_late} !== 2'b01) begin
      errors++; $display("FAIL late_refresh_done got %b exp %b", {a_sd_refresh, a_late}, 2'b01);
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; sd_ready = 1'b0;
    cpu_req = 1'b0; dma_req = 1'b0; cpu_rw = 1'b1; dma_rw = 1'b1;
    cpu_a = '0; dma_a = '0;
    cpu_uds = 1'b1; cpu_lds = 1'b1; dma_uds = 1'b1; dma_lds = 1'b1;
    sd_valid = 1'b1; sd_refdone = 1'b0;
    #1;
    rst_a = 1'b1; rst_b = 1'b1;

    test_reset();
    test_cpu_read();
    test_arbitration();
    test_timeout();
    test_rst_mid_dma();

    rst_b = 1'b1; rst_a = 1'b0;
    test_refresh_idle();
    test_refresh_late();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter REFRESH_INTERVAL, default 128, CLK cycles between refresh requests (legal 8..4095).
REQ-002 Parameter TIMEOUT, default 255, CLK cycles an access may wait for SD_VALID before abort (legal 16..1023).
REQ-003 CLK  input  1  SDRAM clock; all state on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 SD_READY  input  1  high once the SDRAM core has finished power-up init.
REQ-006 CPU_REQ, DMA_REQ  input  1 each  level request, held high until the matching ACK.
REQ-007 CPU_RW, DMA_RW  input  1 each  1=read, 0=write.
REQ-008 CPU_A, DMA_A  input  23 each  word address [23:1].
REQ-009 CPU_UDS, CPU_LDS, DMA_UDS, DMA_LDS  input  1 each  active-low byte strobes.
REQ-010 CPU_ACK, DMA_ACK  output  1 each  one-cycle completion pulse.
REQ-011 CPU_GNT, DMA_GNT  output  1 each  high while that requester owns the SDRAM port.
REQ-012 SD_AS  output  1  active-low access strobe to the SDRAM core.
REQ-013 SD_A  output  23, SD_RW output 1, SD_UDS/SD_LDS output 1 each  latched access fields to the core.
REQ-014 SD_VALID  input  1  active-low; core has completed the current access.
REQ-015 SD_REFRESH  output  1  high requests an auto-refresh from the core.
REQ-016 SD_REFDONE  input  1  one-cycle pulse when the refresh completes.
REQ-017 REFRESH_LATE  output  1  sticky flag, a refresh interval expired with a refresh still pending.
REQ-018 ERR  output  1  one-cycle pulse on access timeout.

Function
REQ-019 States: INIT, IDLE, CPU, DMA, REFRESH, RELEASE; exactly one active.
REQ-020 INIT -> IDLE on the first cycle SD_READY is high; no grant, strobe or refresh in INIT; refresh counter held at 0.
REQ-021 12-bit refresh counter counts 0..REFRESH_INTERVAL-1 and wraps, outside INIT only; on wrap, pending is set.
REQ-022 Wrap with pending already set sets REFRESH_LATE; pending stays single (no queueing).
REQ-023 IDLE priority, evaluated each cycle: pending refresh > CPU_REQ > DMA_REQ.
REQ-024 Exception: if DMA_REQ has been high and not granted for 16 consecutive IDLE-arbitration losses to CPU, DMA wins the next CPU-vs-DMA decision (refresh still higher); loss counter then clears.
REQ-025 Grant entry: SD_A/SD_RW/SD_UDS/SD_LDS latched from the winner on the IDLE->CPU/DMA edge and held constant until RELEASE; GNT and SD_AS low asserted from the next cycle.
REQ-026 CPU/DMA: on first cycle SD_VALID sampled low, pulse that ACK for one cycle, drop GNT, SD_AS high, go RELEASE.
REQ-027 CPU/DMA: if SD_VALID not seen within TIMEOUT cycles of grant, pulse ERR and ACK together, SD_AS high, go RELEASE.
REQ-028 REFRESH: SD_REFRESH high, pending cleared on entry; stay until SD_REFDONE, then SD_REFRESH low, go RELEASE.
REQ-029 RELEASE lasts exactly 1 cycle with SD_AS high and no grant, then IDLE; back-to-back accesses therefore have a minimum 1-cycle strobe gap.
REQ-030 Refresh never pre-empts an access in progress; pending waits for RELEASE->IDLE.
REQ-031 Request deassertion before ACK is ignored; the access completes and ACK still pulses.
REQ-032 Latency: request seen in IDLE -> SD_AS low 1 cycle later; SD_VALID low -> ACK on the same edge's output (registered, next cycle).
REQ-033 SD_READY falling outside INIT: finish current state to RELEASE, then enter INIT.
REQ-034 SD_REFRESH and SD_AS low are never asserted in the same cycle; CPU_GNT and DMA_GNT never both high.

Reset
REQ-035 RST high asynchronously forces: state INIT, SD_AS=1, SD_REFRESH=0, GNT=0, ACK=0, ERR=0, REFRESH_LATE=0, pending=0, counters=0, SD_A=0, SD_RW=1, SD_UDS=SD_LDS=1.
REQ-036 RST mid-access or mid-refresh abandons it with no ACK; core must be re-synchronised via SD_READY.

Verification
REQ-037 SD_READY high, CPU read 0x200000, SD_VALID low 4 cycles after SD_AS -> SD_A=0x200000 stable, one CPU_ACK pulse, one RELEASE cycle with SD_AS high.
REQ-038 CPU_REQ and DMA_REQ held high continuously -> DMA granted on every 17th access, never both GNTs high.
REQ-039 REFRESH_INTERVAL=16, idle bus -> SD_REFRESH every 16+refresh-duration+1 cycles; REFRESH_LATE stays 0.
REQ-040 REFRESH_INTERVAL=16, SD_VALID held high for 40 cycles with TIMEOUT=255 -> refresh waits for access end, REFRESH_LATE sets at second wrap.
REQ-041 TIMEOUT=16, SD_VALID never low -> ERR and CPU_ACK pulse together 16 cycles after grant, then IDLE.
REQ-042 RST pulsed during DMA access -> all outputs at REQ-035 values within same cycle, no DMA_ACK, INIT until SD_READY.
